// File: rtl/esteira_defs.sv
// Shared bottling-line definitions: FSM state encodings and default timings,
// also used by the conveyor motor FSM bench.
package esteira_defs;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    MOVENDO   = 3'd1,
    ENCHENDO  = 3'd2,
    VEDANDO   = 3'd3,
    LIBERANDO = 3'd4,
    ERRO      = 3'd5
  } estado_t;

  localparam int         T_VEDACAO_DEF   = 4;
  localparam int         T_ENCHE_MAX_DEF = 20;
  localparam int         DWELL_W         = 5;
  localparam logic [3:0] ULTIMA_GARRAFA  = 4'd11;
  localparam logic [3:0] MAX_DUZIAS      = 4'd15;

endpackage

// File: rtl/contador_ciclos.sv
// Dwell counter: synchronous clear has priority over enable; result visible the cycle after.
// Asynchronous active-low reset forces the count to zero.
module contador_ciclos #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/controle_envase.sv
// Bottling station controller: conveyor / fill / cap / release sequencing with fill timeout.
// Moore outputs follow the state register; bottle and dozen counters update on cap completion.
module controle_envase
  import esteira_defs::*;
#(
  parameter int T_VEDACAO   = T_VEDACAO_DEF,
  parameter int T_ENCHE_MAX = T_ENCHE_MAX_DEF
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       Parada,
  input  logic       Sensor_Garrafa,
  input  logic       Sensor_Nivel,
  input  logic       Reconhecer,
  output logic       Comando_Mover_Esteira,
  output logic       Valvula_Enchimento,
  output logic       Atuador_Vedacao,
  output logic       Alarme,
  output logic [3:0] Cont_Garrafas,
  output logic [3:0] Cont_Duzias
);

  estado_t              r_state;
  estado_t              w_next;
  logic [DWELL_W-1:0]   w_dwell;
  logic                 w_dwell_clr;
  logic                 w_dwell_en;
  logic                 w_garrafa_pronta;
  logic [3:0]           r_garrafas;
  logic [3:0]           r_duzias;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= OCIOSO;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      OCIOSO:    if (Start) w_next = MOVENDO;
      MOVENDO: begin
        if (Parada)              w_next = OCIOSO;
        else if (Sensor_Garrafa) w_next = ENCHENDO;
      end
      ENCHENDO: begin
        if (Sensor_Nivel)                                w_next = VEDANDO;
        else if (w_dwell == DWELL_W'(T_ENCHE_MAX - 1))   w_next = ERRO;
      end
      VEDANDO:   if (w_dwell == DWELL_W'(T_VEDACAO - 1)) w_next = LIBERANDO;
      LIBERANDO: if (!Sensor_Garrafa) w_next = Parada ? OCIOSO : MOVENDO;
      ERRO:      if (Reconhecer) w_next = OCIOSO;
      default:   w_next = OCIOSO;
    endcase
  end

  always_comb begin
    Comando_Mover_Esteira = 1'b0;
    Valvula_Enchimento    = 1'b0;
    Atuador_Vedacao       = 1'b0;
    Alarme                = 1'b0;
    case (r_state)
      MOVENDO, LIBERANDO: Comando_Mover_Esteira = 1'b1;
      ENCHENDO:           Valvula_Enchimento    = 1'b1;
      VEDANDO:            Atuador_Vedacao       = 1'b1;
      ERRO:               Alarme                = 1'b1;
      default:            ;
    endcase
  end

  // Dwell restarts from zero on every state change, so each timed state counts from its entry.
  assign w_dwell_clr = (w_next != r_state);
  assign w_dwell_en  = (r_state == ENCHENDO) || (r_state == VEDANDO);

  contador_ciclos #(
    .W(DWELL_W)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (Reset_n),
    .i_clr  (w_dwell_clr),
    .i_en   (w_dwell_en),
    .o_count(w_dwell)
  );

  assign w_garrafa_pronta = (r_state == VEDANDO) && (w_next == LIBERANDO);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_garrafas <= '0;
      r_duzias   <= '0;
    end else if (w_garrafa_pronta) begin
      if (r_garrafas == ULTIMA_GARRAFA) begin
        r_garrafas <= '0;
        if (r_duzias != MAX_DUZIAS) r_duzias <= r_duzias + 1'b1;
      end else begin
        r_garrafas <= r_garrafas + 1'b1;
      end
    end
  end

  assign Cont_Garrafas = r_garrafas;
  assign Cont_Duzias   = r_duzias;

endmodule

// File: tb/tb_controle_envase.sv
// Bench for controle_envase: directed scenarios plus randomized bottle runs checked
// against a bottle-level model (fill length, cap length, bottle/dozen totals).
module tb_controle_envase;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       Start, Parada, Sensor_Garrafa, Sensor_Nivel, Reconhecer;
  logic       Comando_Mover_Esteira, Valvula_Enchimento, Atuador_Vedacao, Alarme;
  logic [3:0] Cont_Garrafas, Cont_Duzias;

  int checks   = 0;
  int failures = 0;
  int total    = 0;

  localparam int FILL_MAX = 20;
  localparam int CAP_LEN  = 4;

  controle_envase dut (
    .clk                  (clk),
    .Reset_n              (Reset_n),
    .Start                (Start),
    .Parada               (Parada),
    .Sensor_Garrafa       (Sensor_Garrafa),
    .Sensor_Nivel         (Sensor_Nivel),
    .Reconhecer           (Reconhecer),
    .Comando_Mover_Esteira(Comando_Mover_Esteira),
    .Valvula_Enchimento   (Valvula_Enchimento),
    .Atuador_Vedacao      (Atuador_Vedacao),
    .Alarme               (Alarme),
    .Cont_Garrafas        (Cont_Garrafas),
    .Cont_Duzias          (Cont_Duzias)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int conv, input int valve, input int act, input int alarm);
    chk({tag, "_conveyor"}, int'(Comando_Mover_Esteira), conv);
    chk({tag, "_valve"},    int'(Valvula_Enchimento),    valve);
    chk({tag, "_capper"},   int'(Atuador_Vedacao),       act);
    chk({tag, "_alarm"},    int'(Alarme),                alarm);
  endtask

  // Bottle-level model: counters are just the running total split into dozens.
  task automatic chk_counts(input string tag);
    int duz;
    duz = total / 12;
    if (duz > 15) duz = 15;
    chk({tag, "_bottles"}, int'(Cont_Garrafas), total % 12);
    chk({tag, "_dozens"},  int'(Cont_Duzias),   duz);
  endtask

  // Holds Sensor_Nivel low until the dly-th valve cycle; returns valve-open cycles seen.
  task automatic fill_phase(input int dly, output int vcyc, output int conv_hi);
    vcyc    = 0;
    conv_hi = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!Valvula_Enchimento) break;
      vcyc++;
      if (Comando_Mover_Esteira) conv_hi++;
      Sensor_Nivel = (c == dly);
      tick();
    end
    Sensor_Nivel = 1'b0;
  endtask

  // Precondition: line in MOVENDO with no bottle. Leaves it in MOVENDO afterwards.
  task automatic do_bottle(input int dly, input bit stop_cap, input bit stop_rel);
    int v, ch, a;
    Sensor_Garrafa = 1'b1;
    tick();
    fill_phase(dly, v, ch);
    chk("fill_cycles", v, (dly <= FILL_MAX) ? dly : FILL_MAX);
    chk("conveyor_during_fill", ch, 0);
    if (dly > FILL_MAX) begin
      chk_out("timeout", 0, 0, 0, 1);
      tick(); tick();
      chk("alarm_held", int'(Alarme), 1);
      Reconhecer     = 1'b1;
      Sensor_Garrafa = 1'b0;
      tick();
      Reconhecer = 1'b0;
      chk_out("ack", 0, 0, 0, 0);
      chk_counts("ack");
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("restart_conveyor", int'(Comando_Mover_Esteira), 1);
      return;
    end
    a = 0;
    for (int c = 1; c <= 20; c++) begin
      if (!Atuador_Vedacao) break;
      a++;
      Parada = stop_cap;
      tick();
    end
    Parada = 1'b0;
    chk("cap_cycles", a, CAP_LEN);
    total++;
    chk_out("release", 1, 0, 0, 0);
    chk_counts("release");
    tick();
    chk("release_wait", int'(Comando_Mover_Esteira), 1);
    Sensor_Garrafa = 1'b0;
    Parada         = stop_rel;
    tick();
    Parada = 1'b0;
    chk("after_release_conveyor", int'(Comando_Mover_Esteira), stop_rel ? 0 : 1);
    if (stop_rel) begin
      tick();
      chk("stopped_stays_idle", int'(Comando_Mover_Esteira), 0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
    end
  endtask

  initial begin
    int v, ch, guard;
    Reset_n = 1'b0; Start = 1'b0; Parada = 1'b0;
    Sensor_Garrafa = 1'b0; Sensor_Nivel = 1'b0; Reconhecer = 1'b0;
    #3;
    chk_out("reset", 0, 0, 0, 0);
    chk_counts("reset");
    tick();
    Reset_n = 1'b1;
    tick(); tick();
    chk("idle_without_start", int'(Comando_Mover_Esteira), 0);

    // Normal cycle: start, bottle after 3 moving cycles, level after 5 fill cycles.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_conveyor", int'(Comando_Mover_Esteira), 1);
    tick(); tick();
    chk("moving_conveyor", int'(Comando_Mover_Esteira), 1);
    do_bottle(5, 1'b0, 1'b0);
    chk("first_bottle", int'(Cont_Garrafas), 1);

    // Parada and bottle sensor together in MOVENDO: stop wins, valve stays shut.
    Parada = 1'b1; Sensor_Garrafa = 1'b1;
    tick();
    Parada = 1'b0;
    chk_out("stop_vs_bottle", 0, 0, 0, 0);
    tick();
    chk("stop_vs_bottle_valve", int'(Valvula_Enchimento), 0);
    Sensor_Garrafa = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;

    // Stop requested while capping: the bottle still counts, stop takes effect at release.
    do_bottle(3, 1'b1, 1'b1);
    chk("stop_in_cap_count", int'(Cont_Garrafas), 2);

    // Fill timeout, acknowledge, counters untouched.
    do_bottle(FILL_MAX + 5, 1'b0, 1'b0);
    chk("timeout_count_kept", int'(Cont_Garrafas), 2);

    while (total < 12) do_bottle(int'($urandom_range(1, 6)), 1'b0, 1'b0);
    chk("dozen_wrap_bottles", int'(Cont_Garrafas), 0);
    chk("dozen_wrap_dozens",  int'(Cont_Duzias),   1);

    guard = 0;
    while (total < 200 && guard < 400) begin
      guard++;
      if ($urandom_range(0, 15) == 0)
        do_bottle(int'($urandom_range(FILL_MAX + 1, FILL_MAX + 3)), 1'b0, 1'b0);
      else
        do_bottle(int'($urandom_range(1, 8)), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    chk("random_run_done", int'(total >= 200), 1);
    chk("dozens_saturated", int'(Cont_Duzias), 15);

    // Reset during the second capping cycle.
    Sensor_Garrafa = 1'b1;
    tick();
    fill_phase(3, v, ch);
    chk("pre_reset_capping", int'(Atuador_Vedacao), 1);
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    chk_out("reset_mid_cap", 0, 0, 0, 0);
    total = 0;
    chk_counts("reset_mid_cap");
    Sensor_Garrafa = 1'b0;
    tick();
    Reset_n = 1'b1;
    Sensor_Garrafa = 1'b1;
    tick(); tick(); tick();
    chk_out("needs_start", 0, 0, 0, 0);
    Sensor_Garrafa = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    do_bottle(2, 1'b0, 1'b0);
    chk("after_reset_bottle", int'(Cont_Garrafas), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_envase.md
CONTROLE_ENVASE -- requirements
Module: controle_envase

Interface
REQ-001 The block SHALL take parameter T_VEDACAO, default 4: number of cycles the capping actuator is held.
REQ-002 The block SHALL take parameter T_ENCHE_MAX, default 20: maximum number of cycles allowed in filling before a fault.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Start, input, 1 bit: operator request to run the line.
REQ-006 The block SHALL have port Parada, input, 1 bit: operator stop request.
REQ-007 The block SHALL have port Sensor_Garrafa, input, 1 bit: bottle present at the fill station.
REQ-008 The block SHALL have port Sensor_Nivel, input, 1 bit: bottle filled to level.
REQ-009 The block SHALL have port Reconhecer, input, 1 bit: operator fault acknowledge.
REQ-010 The block SHALL have port Comando_Mover_Esteira, output, 1 bit: move command to the conveyor motor FSM.
REQ-011 The block SHALL have port Valvula_Enchimento, output, 1 bit: fill valve open.
REQ-012 The block SHALL have port Atuador_Vedacao, output, 1 bit: capping actuator on.
REQ-013 The block SHALL have port Alarme, output, 1 bit: fault indicator.
REQ-014 The block SHALL have port Cont_Garrafas, output, 4 bits: bottles in the current dozen, 0..11.
REQ-015 The block SHALL have port Cont_Duzias, output, 4 bits: completed dozens, 0..15.

Function
REQ-016 The FSM SHALL have the states OCIOSO, MOVENDO, ENCHENDO, VEDANDO, LIBERANDO and ERRO.
REQ-017 The outputs SHALL be Moore-decoded from the state register only: Comando_Mover_Esteira=1 in MOVENDO and LIBERANDO; Valvula_Enchimento=1 in ENCHENDO; Atuador_Vedacao=1 in VEDANDO; Alarme=1 in ERRO; all other cases 0.
REQ-018 In OCIOSO, Start=1 SHALL move the FSM to MOVENDO; Start SHALL be ignored in every other state.
REQ-019 In MOVENDO, Parada=1 SHALL move the FSM to OCIOSO; otherwise Sensor_Garrafa=1 SHALL move it to ENCHENDO; if both are 1, Parada wins.
REQ-020 A dwell counter SHALL clear on every state change and increment each cycle that the FSM stays in ENCHENDO or VEDANDO.
REQ-021 In ENCHENDO, Sensor_Nivel=1 SHALL move the FSM to VEDANDO; otherwise a dwell count of T_ENCHE_MAX-1 SHALL move it to ERRO; Sensor_Nivel wins if both conditions hold in the same cycle.
REQ-022 Parada SHALL have no effect in ENCHENDO or VEDANDO; a bottle being worked on is always completed or faulted.
REQ-023 The FSM SHALL remain in VEDANDO for exactly T_VEDACAO cycles and then move to LIBERANDO.
REQ-024 On the VEDANDO->LIBERANDO edge, Cont_Garrafas SHALL increment by 1.
REQ-025 When Cont_Garrafas is 11 on that edge, it SHALL wrap to 0 and Cont_Duzias SHALL increment, saturating at 15.
REQ-026 In LIBERANDO, Sensor_Garrafa=0 SHALL exit the state: to OCIOSO if Parada=1 that cycle, otherwise to MOVENDO.
REQ-027 Comando_Mover_Esteira SHALL fall within one clock of the FSM entering ENCHENDO, so that it is 0 while Valvula_Enchimento=1.
REQ-028 In ERRO, Reconhecer=1 SHALL move the FSM to OCIOSO; the counters SHALL hold their values.
REQ-029 Undefined state encodings SHALL decode to OCIOSO on the next edge.

Reset
REQ-030 While Reset_n=0, independent of clk: state=OCIOSO, dwell counter=0, Cont_Garrafas=0, Cont_Duzias=0, and all actuator and alarm outputs=0.
REQ-031 A reset asserted mid-fill or mid-cap SHALL close the valve and drop the actuator immediately, and the partial bottle SHALL NOT be counted.

Structure
REQ-032 The state encodings and the default values of T_VEDACAO and T_ENCHE_MAX SHALL live in a shared definitions include, esteira_defs, which is also used by the motor FSM bench.
REQ-033 The dwell counter SHALL be a sub-module named contador_ciclos (clear, enable, 5-bit count, async active-low reset); all other logic SHALL stay in one module.

Verification
REQ-034 The bench SHALL cover a normal cycle: Reset_n 0->1, Start=1, Sensor_Garrafa=1 after 3 cycles, Sensor_Nivel=1 after 5 cycles in ENCHENDO, Sensor_Garrafa=0 in LIBERANDO. Required response: valve high 5 cycles, actuator high exactly 4 cycles, Cont_Garrafas=1, FSM returns to MOVENDO.
REQ-035 The bench SHALL cover fill timeout: Sensor_Nivel held 0 in ENCHENDO. Required response: ERRO after exactly 20 cycles of ENCHENDO, Alarme=1, valve=0, and Reconhecer=1 returns the FSM to OCIOSO with the counters unchanged.
REQ-036 The bench SHALL cover wrap-around: 12 full bottle cycles. Required response: Cont_Garrafas returns to 0 and Cont_Duzias=1; after 192 bottles Cont_Duzias stays at 15.
REQ-037 The bench SHALL cover simultaneous events: Parada=1 and Sensor_Garrafa=1 in the same MOVENDO cycle -> OCIOSO, valve never opens; Parada=1 during VEDANDO -> the capping completes and the count increments, then the FSM exits to OCIOSO at the LIBERANDO release.
REQ-038 The bench SHALL cover reset mid-operation: Reset_n=0 in the 2nd VEDANDO cycle. Required response: all outputs 0 in the same cycle, Cont_Garrafas=0, and Start is required to run again.
